// File: rtl/instr_fetch_queue.sv
// ============================================================================
// instr_fetch_queue
// ----------------------------------------------------------------------------
// Purpose:
//   This is the instruction fetch queue between instruction memory and the
//   Tomasulo issue stage. Each cycle it fetches from the fetch PC and writes
//   {pc, instruction} at the queue tail. The issue stage reads from the head.
//   A flush redirects fetch to a new PC and discards everything queued.
//
// Optional feature (macro IFQ_BYPASS_EN):
//   When the macro is defined and the queue is empty, the word being fetched
//   goes straight to the issue stage in the same cycle (zero-cycle latency).
//   If that word is accepted, it is never written into the queue. If it is
//   stalled, it is enqueued as usual. When the macro is undefined, a fetched
//   word appears at the head one cycle after it was fetched.
//
// Parameters:
//   DEPTH     number of queue entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded at reset
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   flush        redirect request, discards queued and in-flight state
//   flush_pc     new fetch PC, sampled when flush is high
//   imem_addr    instruction memory address (the fetch PC)
//   imem_data    combinational instruction memory read data
//   A_stall      ALU reservation station full
//   LS_stall     load/store reservation station full
//   instr        instruction presented to issue
//   instr_pc     PC of instr
//   instr_valid  instr/instr_pc are meaningful
//   full         queue holds DEPTH entries
//   empty        queue holds no entries
//   count        number of occupied entries
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       A_stall,
    input  logic                       LS_stall,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic                       instr_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc    [DEPTH];

    logic deq;
    logic deq_q;
    logic enq;
    logic bypass_taken;

    assign imem_addr = fetch_pc;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
    logic bypass_active;

    // The bypass presents the word being fetched whenever the queue is
    // empty. It is held off during reset so instr_valid reads low while
    // reset is asserted.
    assign bypass_active = empty & ~flush & reset;
    assign instr         = bypass_active ? imem_data : mem_instr[head];
    assign instr_pc      = bypass_active ? fetch_pc  : mem_pc[head];
    assign instr_valid   = ~empty | bypass_active;
    assign bypass_taken  = bypass_active & deq;
`else
    assign instr         = mem_instr[head];
    assign instr_pc      = mem_pc[head];
    assign instr_valid   = ~empty;
    assign bypass_taken  = 1'b0;
`endif

    assign deq = instr_valid & ~A_stall & ~LS_stall;

    // A flush discards any accept from the same cycle. A bypassed accept
    // never touches the head pointer.
    assign deq_q = deq & ~empty & ~flush;

    // A full queue can still take a new word when the head leaves in the
    // same cycle. Then count stays the same and both pointers move.
    assign enq = ~flush & (~full | deq) & ~bypass_taken;

    // Control state. A flush clears the queue and redirects fetch, and it
    // takes priority over enqueue and dequeue. The pointers are a power of
    // two wide, so they wrap modulo DEPTH through natural overflow. The
    // fetch PC wraps modulo 2^32 the same way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else if (flush) begin
            fetch_pc <= flush_pc;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else begin
            if (enq || bypass_taken) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq_q) begin
                head <= head + PW'(1);
            end
            case ({enq, deq_q})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage has no reset. An entry is only read once count shows
    // that it holds a fetched word.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[tail] <= imem_data;
            mem_pc[tail]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// tb_instr_fetch_queue
// ----------------------------------------------------------------------------
// Self-checking bench for instr_fetch_queue. Instruction memory is modelled
// as a pure function of the address. The reference model keeps a queue of
// fetched PCs and a fetch PC. It is built from the accept/enqueue/flush rules
// and works for builds with or without IFQ_BYPASS_EN.
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH + 1);

`ifdef IFQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [31:0]   flush_pc;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          A_stall;
    logic          LS_stall;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    int checks = 0;
    int passes = 0;

    logic [31:0] mq[$];
    logic [31:0] mpc;
    bit          tracking = 1'b0;
    logic [31:0] issued[$];

    typedef struct {
        logic        a_stall;
        logic [31:0] exp_count;
        logic [31:0] exp_addr;
        logic [31:0] exp_head_pc;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    // Instruction memory returns 0x00A00093 at address 0. Every other
    // address returns its own distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00A0_0093;
    endfunction

    assign imem_data = mem_word(imem_addr);

    instr_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .A_stall    (A_stall),
        .LS_stall   (LS_stall),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive all DUT inputs.
    task automatic applyStimulus(input logic f, input logic [31:0] fpc,
                                 input logic a, input logic ls);
        flush    = f;
        flush_pc = fpc;
        A_stall  = a;
        LS_stall = ls;
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = RESET_PC;
    endtask

    function automatic logic model_valid(input logic f);
        return (mq.size() > 0) || (BYPASS && !f);
    endfunction

    // Compare every output against the reference model for the current inputs.
    task automatic checkModel();
        logic [31:0] exp_pc;
        logic        exp_valid;
        exp_pc    = (mq.size() > 0) ? mq[0] : mpc;
        exp_valid = model_valid(flush);
        checkOutput("count",     32'(count),       32'(mq.size()));
        checkOutput("empty",     32'(empty),       32'(mq.size() == 0));
        checkOutput("full",      32'(full),        32'(mq.size() == DEPTH));
        checkOutput("imem_addr", imem_addr,        mpc);
        checkOutput("valid",     32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("instr_pc", instr_pc, exp_pc);
            checkOutput("instr",    instr,    mem_word(exp_pc));
        end
    endtask

    // First half of a cycle: drive inputs just after the edge, then check
    // outputs mid-cycle.
    task automatic cyclePre(input logic f, input logic [31:0] fpc,
                            input logic a, input logic ls);
        applyStimulus(f, fpc, a, ls);
        #4;
        checkModel();
        if (tracking && !f && model_valid(f) && !a && !ls) begin
            issued.push_back(instr_pc);
        end
    endtask

    // Second half of a cycle: clock edge, then advance the reference model.
    task automatic cyclePost();
        logic acc;
        logic was_full;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            mpc = flush_pc;
        end else begin
            acc      = model_valid(1'b0) && !A_stall && !LS_stall;
            was_full = (mq.size() == DEPTH);
            if (acc && mq.size() == 0) begin
                mpc = mpc + 32'd4;
            end else begin
                if (acc) begin
                    void'(mq.pop_front());
                end
                if (!was_full || acc) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
        end
        #1;
    endtask

    task automatic step(input logic f, input logic [31:0] fpc,
                        input logic a, input logic ls);
        cyclePre(f, fpc, a, ls);
        cyclePost();
    endtask

    initial begin
        // Stall pattern from reset: the queue fills to 4, fetch freezes at
        // 0x10, then one word in and one out per cycle while full.
        vecs[0]  = '{1'b1, 32'd0, 32'h00, 32'h00};
        vecs[1]  = '{1'b1, 32'd1, 32'h04, 32'h00};
        vecs[2]  = '{1'b1, 32'd2, 32'h08, 32'h00};
        vecs[3]  = '{1'b1, 32'd3, 32'h0C, 32'h00};
        vecs[4]  = '{1'b1, 32'd4, 32'h10, 32'h00};
        vecs[5]  = '{1'b1, 32'd4, 32'h10, 32'h00};
        vecs[6]  = '{1'b0, 32'd4, 32'h10, 32'h00};
        vecs[7]  = '{1'b0, 32'd4, 32'h14, 32'h04};
        vecs[8]  = '{1'b0, 32'd4, 32'h18, 32'h08};
        vecs[9]  = '{1'b0, 32'd4, 32'h1C, 32'h0C};
        vecs[10] = '{1'b0, 32'd4, 32'h20, 32'h10};

        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Values while reset is held
        checkOutput("rst_count", 32'(count),       32'd0);
        checkOutput("rst_empty", 32'(empty),       32'd1);
        checkOutput("rst_full",  32'(full),        32'd0);
        checkOutput("rst_addr",  imem_addr,        RESET_PC);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        model_reset();
        reset = 1'b1;

        // First fetch after reset release
        cyclePre(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("first_addr", imem_addr, 32'h0);
`ifdef IFQ_BYPASS_EN
        checkOutput("first_instr", instr,             32'h00A0_0093);
        checkOutput("first_pc",    instr_pc,          32'h0);
        checkOutput("first_valid", 32'(instr_valid),  32'd1);
`endif
        cyclePost();
        cyclePre(1'b0, 32'h0, 1'b0, 1'b0);
`ifndef IFQ_BYPASS_EN
        checkOutput("first_instr", instr,             32'h00A0_0093);
        checkOutput("first_pc",    instr_pc,          32'h0);
        checkOutput("first_valid", 32'(instr_valid),  32'd1);
`endif
        cyclePost();

        // Restart from reset for the table-driven stall/full sequence.
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cyclePre(1'b0, 32'h0, vecs[i].a_stall, 1'b0);
            checkOutput($sformatf("tbl%0d_count", i), 32'(count), vecs[i].exp_count);
            checkOutput($sformatf("tbl%0d_addr", i),  imem_addr,  vecs[i].exp_addr);
            checkOutput($sformatf("tbl%0d_full", i),  32'(full),
                        32'(vecs[i].exp_count == DEPTH));
            checkOutput($sformatf("tbl%0d_empty", i), 32'(empty),
                        32'(vecs[i].exp_count == 0));
            if (vecs[i].exp_count != 0) begin
                checkOutput($sformatf("tbl%0d_head", i), instr_pc, vecs[i].exp_head_pc);
            end
            cyclePost();
        end

        // Mid-run reset with two entries queued
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        cyclePre(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("mid_count_before", 32'(count), 32'd2);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_count", 32'(count),       32'd0);
        checkOutput("mid_rst_empty", 32'(empty),       32'd1);
        checkOutput("mid_rst_full",  32'(full),        32'd0);
        checkOutput("mid_rst_addr",  imem_addr,        RESET_PC);
        checkOutput("mid_rst_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_hold_count", 32'(count), 32'd0);
        checkOutput("mid_rst_hold_addr",  imem_addr,  RESET_PC);
        model_reset();
        reset = 1'b1;

        // Flush while three entries are queued
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        cyclePre(1'b1, 32'h40, 1'b0, 1'b0);
        checkOutput("flush_count_before", 32'(count), 32'd3);
        cyclePost();
        cyclePre(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_addr",  imem_addr,  32'h40);
`ifdef IFQ_BYPASS_EN
        checkOutput("flush_issue_pc",    instr_pc,         32'h40);
        checkOutput("flush_issue_valid", 32'(instr_valid), 32'd1);
        cyclePost();
`else
        cyclePost();
        cyclePre(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("flush_issue_pc",    instr_pc,         32'h40);
        checkOutput("flush_issue_valid", 32'(instr_valid), 32'd1);
        cyclePost();
`endif

        // LS_stall toggling every cycle: issued PCs must step by exactly 4.
        issued.delete();
        tracking = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'(i % 2));
        end
        tracking = 1'b0;
        checkOutput("alt_issue_count", 32'(issued.size() >= 9), 32'd1);
        for (int i = 1; i < issued.size(); i++) begin
            checkOutput($sformatf("alt_seq%0d", i), issued[i], issued[i-1] + 32'd4);
        end

        // PC wrap modulo 2^32
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'(i == 2));
        end

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic        f;
            logic [31:0] fpc;
            f   = ($urandom_range(0, 99) < 3);
            fpc = $urandom & 32'hFFFF_FFFC;
            step(f, fpc, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: value loaded into the fetch PC at reset.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  redirect request; discards all queued and in-flight fetch state.
REQ-006 flush_pc  input  32  new fetch address, sampled when flush=1.
REQ-007 imem_addr  output  32  instruction memory read address; equals the fetch PC register.
REQ-008 imem_data  input  32  combinational instruction memory read data for imem_addr.
REQ-009 A_stall  input  1  ALU reservation station full; the presented instruction is not accepted.
REQ-010 LS_stall  input  1  load/store reservation station full; the presented instruction is not accepted.
REQ-011 instr  output  32  instruction presented to the Tomasulo issue stage.
REQ-012 instr_pc  output  32  PC of instr.
REQ-013 instr_valid  output  1  instr and instr_pc are meaningful.
REQ-014 full  output  1  count equals DEPTH.
REQ-015 empty  output  1  count equals 0.
REQ-016 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 Accept: deq = instr_valid & ~A_stall & ~LS_stall; an instruction is consumed only in a cycle where deq=1.
REQ-018 Enqueue: enq = ~flush & (~full | deq) & ~bypass_taken; on enq, write {fetch_pc, imem_data} at the tail, advance the tail pointer modulo DEPTH, and set fetch_pc <= fetch_pc + 4.
REQ-019 Dequeue: on deq from a non-empty queue, advance the head pointer modulo DEPTH.
REQ-020 Outputs instr and instr_pc SHALL come from the head entry combinationally; instr_valid = ~empty, except as extended by REQ-028.
REQ-021 Simultaneous enq and deq SHALL leave count unchanged, including when full; the pointers SHALL wrap independently.
REQ-022 When full and deq=0, there is no enqueue and fetch_pc holds, so imem_addr is stable.
REQ-023 Flush has priority over all other events: count <= 0, head <= 0, tail <= 0, fetch_pc <= flush_pc; no enqueue occurs that cycle, and a deq in the same cycle is ignored.
REQ-024 fetch_pc SHALL wrap modulo 2^32 on overflow.
REQ-025 Minimum latency without bypass: an instruction fetched in cycle N is presented with instr_valid=1 in cycle N+1.

Reset
REQ-026 While reset=0, asynchronously set: fetch_pc=RESET_PC, head=0, tail=0, count=0; therefore imem_addr=RESET_PC, instr_valid=0, empty=1, full=0.
REQ-027 Entry storage is not reset; instr and instr_pc are don't-care while instr_valid=0. A reset asserted mid-operation discards all entries.

Configuration
REQ-028 Macro IFQ_BYPASS_EN.
- Defined: when empty=1 and flush=0, instr=imem_data, instr_pc=fetch_pc, and instr_valid=1 combinationally. If that instruction is accepted (bypass_taken = deq with empty=1), fetch_pc advances by 4 with no enqueue. If it is stalled, it is enqueued normally. Zero-cycle latency.
- Undefined: no bypass path exists, bypass_taken=0, and REQ-025 latency applies.

Verification
REQ-029 Reset release with RESET_PC=0, no stalls, memory returning 0x00A00093 at address 0 -> imem_addr=0. Without bypass, cycle 1 shows instr=0x00A00093, instr_pc=0, instr_valid=1. With bypass, the same values appear in cycle 0.
REQ-030 A_stall=1 held for 6 cycles with DEPTH=4 -> count rises 1,2,3,4, then full=1; imem_addr freezes at 0x10; PCs 0x0..0xC are later issued in order after the stall releases.
REQ-031 Full queue with A_stall=0 for 1 cycle -> one dequeue and one enqueue; count stays 4; head and tail wrap to index 0 after 4 such cycles.
REQ-032 flush=1, flush_pc=0x40 while count=3 and LS_stall=0 -> next cycle count=0, empty=1, imem_addr=0x40; the next issued instr_pc=0x40.
REQ-033 reset asserted mid-run with count=2 -> outputs return to the REQ-026 values immediately, without waiting for a clock edge.
REQ-034 Alternating LS_stall every cycle for 20 cycles -> the issued PC sequence is strictly +4 with no duplicates or gaps.
